// File: rtl/quad_input_conditioner_if.sv
// Signal bundle between the rotary-encoder GPIO pins and the quadrature conditioner.
// The master drives the raw pins; the slave returns conditioned levels and strobes.
interface quad_input_conditioner_if #(
  parameter int unsigned ERR_W = 8
) ();
  logic             quad_a_raw;
  logic             quad_b_raw;
  logic             sw_raw;
  logic             quad_a;
  logic             quad_b;
  logic             step_up;
  logic             step_down;
  logic             sw_level;
  logic             sw_pressed;
  logic             illegal;
  logic [ERR_W-1:0] illegal_count;

  modport master (
    output quad_a_raw, quad_b_raw, sw_raw,
    input  quad_a, quad_b, step_up, step_down, sw_level, sw_pressed, illegal, illegal_count
  );

  modport slave (
    input  quad_a_raw, quad_b_raw, sw_raw,
    output quad_a, quad_b, step_up, step_down, sw_level, sw_pressed, illegal, illegal_count
  );
endinterface

// File: rtl/quad_input_conditioner.sv
// Synchronises and debounces encoder A/B and push-switch, then decodes Gray-code steps.
// The decoder stays disarmed for a startup window so a non-00 resting position is not a step.
module quad_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned ERR_W           = 8
) (
  input logic                     clk,
  input logic                     resetn,
  quad_input_conditioner_if.slave cond_if
);

  localparam int unsigned CntW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned StartCycles = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int unsigned StartW      = $clog2(StartCycles + 1);
  // Channel 0 = A, 1 = B, 2 = switch; the switch idles high so its path resets to 1.
  localparam logic [2:0] ChanRst = 3'b100;

  logic [2:0] raw;
  logic [2:0] deb;

  assign raw = {cond_if.sw_raw, cond_if.quad_b_raw, cond_if.quad_a_raw};

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   deb_q, deb_d;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw[c]};
      cnt_d  = '0;
      deb_d  = deb_q;
      if (sync_q[SYNC_STAGES-1] != deb_q) begin
        if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d = ~deb_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_q <= {SYNC_STAGES{ChanRst[c]}};
        cnt_q  <= '0;
        deb_q  <= ChanRst[c];
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        deb_q  <= deb_d;
      end
    end

    assign deb[c] = deb_q;
  end

  logic [StartW-1:0] start_q, start_d;
  logic              armed;
  logic [1:0]        cur_ab;
  logic [1:0]        prev_ab_q, prev_ab_d;
  logic              fwd, rev, both;
  logic              sw_level;
  logic              sw_prev_q, sw_prev_d;
  logic              step_up_q, step_up_d;
  logic              step_down_q, step_down_d;
  logic              illegal_q, illegal_d;
  logic              sw_pressed_q, sw_pressed_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  assign cur_ab   = {deb[0], deb[1]};
  assign armed    = (start_q == StartW'(StartCycles));
  assign sw_level = ~deb[2];

  always_comb begin
    start_d   = armed ? start_q : start_q + 1'b1;
    prev_ab_d = cur_ab;
    sw_prev_d = sw_level;
    fwd       = 1'b0;
    rev       = 1'b0;
    // Clockwise walks 00->10->11->01->00; the reverse walk is counter-clockwise.
    case ({prev_ab_q, cur_ab})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: rev = 1'b1;
      default: ;
    endcase
    both         = &(prev_ab_q ^ cur_ab);
    step_up_d    = armed & fwd;
    step_down_d  = armed & rev;
    illegal_d    = armed & both;
    sw_pressed_d = armed & sw_level & ~sw_prev_q;
    err_cnt_d    = err_cnt_q;
    if (illegal_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q      <= '0;
      prev_ab_q    <= '0;
      sw_prev_q    <= 1'b0;
      step_up_q    <= 1'b0;
      step_down_q  <= 1'b0;
      illegal_q    <= 1'b0;
      sw_pressed_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      start_q      <= start_d;
      prev_ab_q    <= prev_ab_d;
      sw_prev_q    <= sw_prev_d;
      step_up_q    <= step_up_d;
      step_down_q  <= step_down_d;
      illegal_q    <= illegal_d;
      sw_pressed_q <= sw_pressed_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign cond_if.quad_a        = deb[0];
  assign cond_if.quad_b        = deb[1];
  assign cond_if.step_up       = step_up_q;
  assign cond_if.step_down     = step_down_q;
  assign cond_if.sw_level      = sw_level;
  assign cond_if.sw_pressed    = sw_pressed_q;
  assign cond_if.illegal       = illegal_q;
  assign cond_if.illegal_count = err_cnt_q;

endmodule

// File: tb/tb_quad_input_conditioner.sv
// Bench for quad_input_conditioner: directed scenarios plus random pin activity,
// each cycle compared against a rule-level model of sync, debounce and Gray decoding.
module tb_quad_input_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int ERRW  = 8;
  localparam int START = SYNC + DEB + 1;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk = ~clk;

  quad_input_conditioner_if #(.ERR_W(ERRW)) cif ();

  quad_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .ERR_W          (ERRW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .cond_if(cif)
  );

  // Reference model: raw pins delayed SYNC edges, a level is accepted after DEB
  // consecutive disagreeing cycles, direction from Gray position difference mod 4.
  logic [2:0] m_hist [SYNC];
  logic [2:0] m_raw, m_syn, m_deb;
  int         m_run [3];
  int         m_ticks, m_cnt, m_d;
  logic [1:0] m_prev, m_cur;
  logic       m_armed, m_level, m_swp;
  logic       m_up, m_dn, m_ill, m_press;

  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  assign m_raw   = {cif.sw_raw, cif.quad_b_raw, cif.quad_a_raw};
  assign m_syn   = m_hist[SYNC-1];
  assign m_cur   = {m_deb[0], m_deb[1]};
  assign m_armed = (m_ticks >= START);
  assign m_level = ~m_deb[2];
  assign m_d     = (gray_pos(m_cur) + 4 - gray_pos(m_prev)) % 4;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] <= 3'b100;
      for (int c = 0; c < 3; c++) m_run[c] <= 0;
      m_deb   <= 3'b100;
      m_ticks <= 0;
      m_prev  <= 2'b00;
      m_up    <= 1'b0;
      m_dn    <= 1'b0;
      m_ill   <= 1'b0;
      m_press <= 1'b0;
      m_swp   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      m_hist[0] <= m_raw;
      for (int i = 1; i < SYNC; i++) m_hist[i] <= m_hist[i-1];
      for (int c = 0; c < 3; c++) begin
        if (m_syn[c] == m_deb[c]) m_run[c] <= 0;
        else if (m_run[c] + 1 == DEB) begin
          m_run[c] <= 0;
          m_deb[c] <= ~m_deb[c];
        end else m_run[c] <= m_run[c] + 1;
      end
      if (m_ticks < 1000) m_ticks <= m_ticks + 1;
      m_prev  <= m_cur;
      m_up    <= m_armed && (m_d == 1);
      m_dn    <= m_armed && (m_d == 3);
      m_ill   <= m_armed && (m_d == 2);
      if (m_armed && (m_d == 2) && (m_cnt < (1 << ERRW) - 1)) m_cnt <= m_cnt + 1;
      m_press <= m_armed && m_level && !m_swp;
      m_swp   <= m_level;
    end
  end

  logic [14:0] obs, exp_v;
  assign obs   = {cif.quad_a, cif.quad_b, cif.step_up, cif.step_down, cif.sw_level,
                  cif.sw_pressed, cif.illegal, cif.illegal_count};
  assign exp_v = {m_deb[0], m_deb[1], m_up, m_dn, m_level, m_press, m_ill, 8'(m_cnt)};

  task automatic test_reset();
    int lat = 0;
    int pulses = 0;
    cif.quad_a_raw = 1'b1;
    cif.quad_b_raw = 1'b1;
    cif.sw_raw     = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== 15'd0) begin bad++; $display("FAIL reset_state got=%h want=0", obs); end
    resetn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL reset_model t=%0t got=%h want=%h", $time, obs, exp_v);
      end
      if (cif.quad_a && lat == 0) lat = k;
      if (cif.step_up || cif.step_down || cif.illegal) pulses++;
    end
    total++;
    if (lat != SYNC + DEB) begin bad++; $display("FAIL reset_ab_latency got=%0d want=%0d", lat, SYNC + DEB); end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL reset_no_pulse got=%0d want=0", pulses); end
    total++;
    if (cif.illegal_count !== 8'd0) begin
      bad++; $display("FAIL reset_err_cnt got=%0d want=0", cif.illegal_count);
    end
  endtask

  task automatic test_cw();
    logic [1:0] seq [6];
    int ups = 0, dns = 0, late = 0;
    seq = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 6; i++) begin
      cif.quad_a_raw = seq[i][1];
      cif.quad_b_raw = seq[i][0];
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        total++;
        if (obs !== exp_v) begin
          bad++; $display("FAIL cw_model t=%0t got=%h want=%h", $time, obs, exp_v);
        end
        if (cif.step_down) dns++;
        if (i >= 2 && cif.step_up) begin ups++; if (k != SYNC + DEB + 1) late++; end
      end
    end
    total++;
    if (ups != 4) begin bad++; $display("FAIL cw_ups got=%0d want=4", ups); end
    total++;
    if (late != 0) begin bad++; $display("FAIL cw_timing got=%0d off-time pulses want=0", late); end
    total++;
    if (dns != 0) begin bad++; $display("FAIL cw_no_down got=%0d want=0", dns); end
  endtask

  task automatic test_ccw();
    logic [1:0] seq [4];
    int ups = 0, dns = 0, late = 0;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      cif.quad_a_raw = seq[i][1];
      cif.quad_b_raw = seq[i][0];
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        total++;
        if (obs !== exp_v) begin
          bad++; $display("FAIL ccw_model t=%0t got=%h want=%h", $time, obs, exp_v);
        end
        if (cif.step_up) ups++;
        if (cif.step_down) begin dns++; if (k != SYNC + DEB + 1) late++; end
      end
    end
    total++;
    if (dns != 4) begin bad++; $display("FAIL ccw_downs got=%0d want=4", dns); end
    total++;
    if (late != 0) begin bad++; $display("FAIL ccw_timing got=%0d off-time pulses want=0", late); end
    total++;
    if (ups != 0) begin bad++; $display("FAIL ccw_no_up got=%0d want=0", ups); end
  endtask

  task automatic test_bounce();
    int rises = 0, falls = 0, steps = 0, b_high = 0;
    logic qa_prev = 1'b0;
    for (int k = 0; k < 70; k++) begin
      cif.quad_a_raw = (k < 2) || (k >= 4 && k != 30);
      cif.quad_b_raw = (k == 50);
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL bounce_model t=%0t got=%h want=%h", $time, obs, exp_v);
      end
      if (cif.quad_a && !qa_prev) rises++;
      if (!cif.quad_a && qa_prev) falls++;
      qa_prev = cif.quad_a;
      if (cif.step_up || cif.step_down) steps++;
      if (cif.quad_b) b_high++;
    end
    total++;
    if (rises != 1 || falls != 0) begin
      bad++; $display("FAIL bounce_edges got rise=%0d fall=%0d want rise=1 fall=0", rises, falls);
    end
    total++;
    if (steps != 1) begin bad++; $display("FAIL bounce_steps got=%0d want=1", steps); end
    total++;
    if (b_high != 0) begin bad++; $display("FAIL glitch_b got=%0d want=0", b_high); end
  endtask

  task automatic test_illegal();
    int ills = 0, steps = 0;
    cif.quad_a_raw = 1'b0;
    cif.quad_b_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL ill_pre_model t=%0t got=%h want=%h", $time, obs, exp_v);
      end
    end
    for (int f = 1; f <= 300; f++) begin
      cif.quad_a_raw = f[0];
      cif.quad_b_raw = f[0];
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        total++;
        if (obs !== exp_v) begin
          bad++; $display("FAIL ill_model t=%0t got=%h want=%h", $time, obs, exp_v);
        end
        if (cif.illegal) ills++;
        if (cif.step_up || cif.step_down) steps++;
      end
      if (f == 1) begin
        total++;
        if (ills != 1 || cif.illegal_count !== 8'd1) begin
          bad++; $display("FAIL ill_first got pulses=%0d cnt=%0d want 1/1", ills, cif.illegal_count);
        end
      end
    end
    total++;
    if (ills != 300 || steps != 0) begin
      bad++; $display("FAIL ill_pulses got=%0d steps=%0d want 300/0", ills, steps);
    end
    repeat (20) @(negedge clk);
    total++;
    if (cif.illegal_count !== 8'd255) begin
      bad++; $display("FAIL ill_saturate got=%0d want=255", cif.illegal_count);
    end
  endtask

  task automatic test_switch();
    int lvl_lat = 0, presses = 0, press_k = 0, both = 0, lvl_short = 0;
    cif.quad_a_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cif.sw_raw = (k >= 10);
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL sw_model t=%0t got=%h want=%h", $time, obs, exp_v);
      end
      if (cif.sw_level && lvl_lat == 0) lvl_lat = k + 1;
      if (cif.sw_pressed) begin presses++; press_k = k + 1; end
      if (cif.sw_pressed && cif.step_up) both++;
    end
    total++;
    if (lvl_lat != SYNC + DEB) begin bad++; $display("FAIL sw_latency got=%0d want=%0d", lvl_lat, SYNC + DEB); end
    total++;
    if (presses != 1 || press_k != SYNC + DEB + 1) begin
      bad++; $display("FAIL sw_press got=%0d at=%0d want 1 at %0d", presses, press_k, SYNC + DEB + 1);
    end
    total++;
    if (both != 1) begin bad++; $display("FAIL sw_coincide got=%0d want=1", both); end
    presses = 0;
    for (int k = 0; k < 30; k++) begin
      cif.sw_raw = (k >= 3);
      @(negedge clk);
      if (cif.sw_level) lvl_short++;
      if (cif.sw_pressed) presses++;
    end
    total++;
    if (lvl_short != 0 || presses != 0) begin
      bad++; $display("FAIL sw_short got lvl=%0d press=%0d want 0/0", lvl_short, presses);
    end
  endtask

  task automatic test_random();
    int hold [3] = '{0, 0, 0};
    int clash = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          hold[c] = $urandom_range(1, 12);
          case (c)
            0:       cif.quad_a_raw = 1'($urandom_range(0, 1));
            1:       cif.quad_b_raw = 1'($urandom_range(0, 1));
            default: cif.sw_raw     = 1'($urandom_range(0, 1));
          endcase
        end
        hold[c]--;
      end
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL rand_model t=%0t got=%h want=%h", $time, obs, exp_v);
      end
      if (cif.step_up && cif.step_down) clash++;
    end
    total++;
    if (clash != 0) begin bad++; $display("FAIL rand_up_down_clash got=%0d want=0", clash); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0, lat = 0, waited = 0;
    bit seen = 1'b0;
    cif.sw_raw     = 1'b1;
    cif.quad_a_raw = 1'b0;
    cif.quad_b_raw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL mid_pre_model t=%0t got=%h want=%h", $time, obs, exp_v);
      end
    end
    cif.quad_a_raw = 1'b1;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      seen = cif.step_up;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_step_seen got=0 want=1"); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (obs !== 15'd0) begin bad++; $display("FAIL mid_async_clear got=%h want=0", obs); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL mid_post_model t=%0t got=%h want=%h", $time, obs, exp_v);
      end
      if (cif.step_up || cif.step_down || cif.illegal || cif.sw_pressed) pulses++;
      if (cif.quad_a && lat == 0) lat = k;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL mid_startup_pulses got=%0d want=0", pulses); end
    total++;
    if (lat != SYNC + DEB) begin bad++; $display("FAIL mid_relatch got=%0d want=%0d", lat, SYNC + DEB); end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_bounce();
    test_illegal();
    test_switch();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
